ahb_mprj_io_ctrl: RTL and testbench
===================================

// Module: ahb_mprj_io_ctrl
// PURPOSE
//  AHB-Lite slave that sits downstream of the user project wrapper's AHB port and owns the MPRJ IO pads.
//  Provides memory-mapped output, output-enable and input registers.
//  Detects rising edges on the pads and raises a maskable interrupt that the wrapper routes to user_irq.
//  Zero-wait-state slave; HREADYOUT is always 1.
// PARAMETERS
//  IO_PADS   38  number of pads handled (33..64); bits [IO_PADS-1:32] live in the *_HI registers
// PORTS
//  HCLK       in   1        single system clock
//  HRESETn    in   1        synchronous, active-low reset
//  HSEL       in   1        slave select
//  HADDR      in   32       byte address; only HADDR[5:0] is decoded
//  HTRANS     in   2        transfer type; NONSEQ/SEQ (HTRANS[1]=1) are valid
//  HWRITE     in   1        1 = write
//  HSIZE      in   3        0 = byte, 1 = half, 2 = word
//  HWDATA     in   32       write data, valid in the data phase
//  HREADY     in   1        bus ready; an address phase is accepted only when it is 1
//  HRDATA     out  32       read data, valid in the data phase
//  HREADYOUT  out  1        constant 1
//  io_in      in   IO_PADS  pad inputs
//  io_out     out  IO_PADS  pad outputs
//  io_oeb     out  IO_PADS  pad output enables, active low
//  irq        out  1        level interrupt = |(IRQ_STAT & RISE_EN)
// BEHAVIOUR
//  Address phase
//   - Accepted when HSEL & HREADY & HTRANS[1].
//   - Registers HADDR[5:2], HWRITE, and a 4-bit byte lane mask from HSIZE/HADDR[1:0] into a valid flag.
//   - Any other cycle with HREADY=1 clears the valid flag.
//  Data phase (cycle after acceptance)
//   - Write: the selected register updates at the end of the data phase, on the enabled byte lanes only.
//   - Read: HRDATA is a combinational mux of the registers, addressed by the latched address.
//   - HRDATA = 0 when the valid flag is clear or the address is unmapped.
//   - Read-after-write to the same register in back-to-back transfers returns the new value.
//  Register map (offset, access, reset value)
//   0x00 OUT_LO      RW   0           io_out[31:0]
//   0x04 OUT_HI      RW   0           io_out[IO_PADS-1:32]
//   0x08 OEB_LO      RW   all 1       io_oeb[31:0]
//   0x0C OEB_HI      RW   all 1       io_oeb[IO_PADS-1:32]
//   0x10 IN_LO       RO   0           synchronised io_in[31:0]
//   0x14 IN_HI       RO   0           synchronised io_in[IO_PADS-1:32]
//   0x18 RISE_EN_LO  RW   0           rising-edge interrupt enable
//   0x1C RISE_EN_HI  RW   0           rising-edge interrupt enable
//   0x20 STAT_LO     W1C  0           sticky edge flags
//   0x24 STAT_HI     W1C  0           sticky edge flags
//   0x28..0x3C       unmapped: reads 0, writes ignored
//  Width rules
//   - *_HI registers implement IO_PADS-32 bits; unimplemented bits read 0.
//   - OUT/OEB drive io_out/io_oeb directly from flops; no combinational path from the bus.
//  Edge detection
//   - prev <= sampled input every cycle.
//   - STAT[i] sets when sampled[i] & ~prev[i], regardless of RISE_EN.
//   - A simultaneous W1C and new edge on the same bit: the set wins (bit stays 1).
//   - irq is registered: it asserts 1 cycle after STAT & RISE_EN becomes nonzero and drops 1 cycle after it clears.
//  Reset
//   - While HRESETn=0 at a clock edge: all registers and the valid flag take their reset values.
//   - Outputs: io_out=0, io_oeb=all 1, irq=0, HRDATA=0.
//   - The edge-history flops load 0, so a pad high out of reset sets STAT one sample after release.
//   - Reset asserted mid-transfer abandons the transfer; no register is written.
// CONFIGURATION
//  MPRJ_IO_SYNC_EN defined
//   - io_in passes a 2-flop synchroniser before the IN registers and edge detection.
//   - Pad-to-IN latency is 2 cycles; pad-to-irq is 4 cycles.
//  MPRJ_IO_SYNC_EN undefined
//   - A single sampling flop is used.
//   - Pad-to-IN latency is 1 cycle; pad-to-irq is 3 cycles.
// TESTING
//  T1 Reset, then read 0x00, 0x08, 0x0C, 0x20
//     -> 0, 0xFFFFFFFF, 0x3F (IO_PADS=38), 0; io_oeb = all 1.
//  T2 Word write 0xA5A5A5A5 to 0x00, then byte write 0x3C to 0x01
//     -> io_out[31:0] = 0xA5A53CA5 one cycle after the second data phase; read-back matches.
//  T3 Write 0x3FFFFFFF to 0x04
//     -> io_out[37:32] = 0x3F; read 0x04 returns 0x3F.
//  T4 RISE_EN_LO=0x1, io_in[0] 0->1
//     -> STAT_LO=0x1 and irq=1 at the latency per the macro.
//     -> Write 0x1 to 0x20 -> irq=0 next cycle.
//  T5 io_in[0] rises in the same cycle as a W1C of bit 0
//     -> STAT_LO[0] remains 1 and irq stays 1.
//  T6 Back-to-back write then read of 0x08 with HTRANS=SEQ
//     -> read returns the new value.
//     -> Read of unmapped 0x30 -> 0.
//     -> HTRANS=IDLE write -> no register change.

Source files
------------

// File: rtl/ahb_mprj_io_ctrl.sv
// ahb_mprj_io_ctrl: zero-wait AHB-Lite slave owning the MPRJ pads, with a rising-edge interrupt.
// Define MPRJ_IO_SYNC_EN to put a 2-flop synchroniser in front of the IN registers and edge detection.
module ahb_mprj_io_ctrl #(
  parameter int IO_PADS = 38
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               HSEL,
  input  logic [31:0]        HADDR,
  input  logic [1:0]         HTRANS,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic [31:0]        HWDATA,
  input  logic               HREADY,
  output logic [31:0]        HRDATA,
  output logic               HREADYOUT,
  input  logic [IO_PADS-1:0] io_in,
  output logic [IO_PADS-1:0] io_out,
  output logic [IO_PADS-1:0] io_oeb,
  output logic               irq
);
  localparam int HW = IO_PADS - 32;
  logic               valid, wr, we, accept, unused;
  logic [3:0]         addr, lanes, lanes_d;
  logic [31:0]        mask;
  logic [IO_PADS-1:0] out_r, oeb_r, en_r, stat_r, smp, prev, rise, wd;
  logic [IO_PADS-1:0] wm_out, wm_oeb, wm_en, wm_stat;
  function automatic logic [IO_PADS-1:0] sel_mask(input logic [3:0] a, input logic [3:0] base,
                                                  input logic [31:0] m);
    return a == base ? {{HW{1'b0}}, m} : a == base + 4'd1 ? {m[HW-1:0], 32'h0} : '0;
  endfunction
  function automatic logic [31:0] word_of(input logic [IO_PADS-1:0] x, input logic hi);
    logic [63:0] t;
    t = '0;
    t[IO_PADS-1:0] = x;
    return hi ? t[63:32] : t[31:0];
  endfunction
  assign unused = ^{HADDR[31:6], HTRANS[0]};
  assign accept = HSEL & HREADY & HTRANS[1];
  assign we = valid & wr;
  assign mask = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
  assign wd = {HWDATA[HW-1:0], HWDATA};
  assign wm_out = we ? sel_mask(addr, 4'd0, mask) : '0;
  assign wm_oeb = we ? sel_mask(addr, 4'd2, mask) : '0;
  assign wm_en = we ? sel_mask(addr, 4'd6, mask) : '0;
  assign wm_stat = we ? sel_mask(addr, 4'd8, mask) : '0;
  assign rise = smp & ~prev;
  assign HREADYOUT = 1'b1;
  assign io_out = out_r;
  assign io_oeb = oeb_r;
  always_comb
    lanes_d = HSIZE == 3'd0 ? 4'b0001 << HADDR[1:0] :
              HSIZE == 3'd1 ? (HADDR[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  always_comb
    HRDATA = !valid ? 32'h0 :
             addr[3:1] == 3'd0 ? word_of(out_r, addr[0]) :
             addr[3:1] == 3'd1 ? word_of(oeb_r, addr[0]) :
             addr[3:1] == 3'd2 ? word_of(smp, addr[0]) :
             addr[3:1] == 3'd3 ? word_of(en_r, addr[0]) :
             addr[3:1] == 3'd4 ? word_of(stat_r, addr[0]) : 32'h0;
`ifdef MPRJ_IO_SYNC_EN
  logic [IO_PADS-1:0] meta;
  always_ff @(posedge HCLK) begin
    meta <= HRESETn ? io_in : '0;
    smp <= HRESETn ? meta : '0;
  end
`else
  always_ff @(posedge HCLK)
    smp <= HRESETn ? io_in : '0;
`endif
  always_ff @(posedge HCLK)
    if (!HRESETn) begin
      valid <= 1'b0;
      wr <= 1'b0;
      addr <= '0;
      lanes <= '0;
      out_r <= '0;
      oeb_r <= '1;
      en_r <= '0;
      stat_r <= '0;
      prev <= '0;
      irq <= 1'b0;
    end else begin
      if (HREADY)
        valid <= accept;
      if (accept) begin
        addr <= HADDR[5:2];
        wr <= HWRITE;
        lanes <= lanes_d;
      end
      out_r <= (out_r & ~wm_out) | (wd & wm_out);
      oeb_r <= (oeb_r & ~wm_oeb) | (wd & wm_oeb);
      en_r <= (en_r & ~wm_en) | (wd & wm_en);
      // a new edge overrides a same-cycle clear
      stat_r <= (stat_r & ~(wd & wm_stat)) | rise;
      prev <= smp;
      irq <= |(stat_r & en_r);
    end
endmodule

// File: tb/tb_ahb_mprj_io_ctrl.sv
// tb_ahb_mprj_io_ctrl: directed and randomized checks of ahb_mprj_io_ctrl against a pad-history model.
module tb_ahb_mprj_io_ctrl;
  localparam int P = 38;
  localparam logic [63:0] PM = (64'd1 << P) - 64'd1;
`ifdef MPRJ_IO_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic HSEL = 1'b0, HWRITE = 1'b0, HREADY = 1'b1, HREADYOUT, irq;
  logic [1:0] HTRANS = 2'b00;
  logic [2:0] HSIZE = 3'd0;
  logic [31:0] HADDR = '0, HWDATA = '0, HRDATA, v;
  logic [P-1:0] io_in = '0, io_out, io_oeb;
  int checks = 0, failures = 0, n;
  logic [63:0] m_out, m_oeb, m_en, m_stat, last_pad;
  logic [63:0] samp[$];
  logic m_irq, pv, pw;
  logic [5:0] pa;
  logic [31:0] pm32;

  ahb_mprj_io_ctrl #(.IO_PADS(P)) dut (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .io_in(io_in), .io_out(io_out),
    .io_oeb(io_oeb), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd();
    logic [63:0] r;
    case (pa[5:3])
      3'd0: r = m_out;
      3'd1: r = m_oeb;
      3'd2: r = samp[samp.size()-1];
      3'd3: r = m_en;
      3'd4: r = m_stat;
      default: r = '0;
    endcase
    return !pv ? 32'h0 : pa[2] ? r[63:32] : r[31:0];
  endfunction

  task automatic check_all();
    chk("io_out", 64'(io_out), m_out);
    chk("io_oeb", 64'(io_oeb), m_oeb);
    chk("irq", 64'(irq), 64'(m_irq));
    chk("hreadyout", 64'(HREADYOUT), 64'd1);
    if (!(pv && pw))
      chk("hrdata", 64'(HRDATA), 64'(exp_rd()));
  endtask

  // Model: registers as whole 64-bit vectors, sampled pads kept as a history queue.
  task automatic tick();
    logic [63:0] wm, wd, clr, rise, s_new;
    @(posedge clk);
    if (!rst_n) begin
      m_out = '0; m_oeb = PM; m_en = '0; m_stat = '0; m_irq = 1'b0;
      pv = 1'b0; pw = 1'b0; last_pad = '0;
      samp.push_back('0);
    end else begin
      wm = (pv && pw) ? (pa[2] ? {pm32, 32'h0} : {32'h0, pm32}) : '0;
      wd = {2{HWDATA}};
      clr = '0;
      rise = samp[samp.size()-1] & ~samp[samp.size()-2];
      m_irq = |(m_stat & m_en);
      case (pa[5:3])
        3'd0: m_out = ((m_out & ~wm) | (wd & wm)) & PM;
        3'd1: m_oeb = ((m_oeb & ~wm) | (wd & wm)) & PM;
        3'd3: m_en = ((m_en & ~wm) | (wd & wm)) & PM;
        3'd4: clr = wd & wm;
        default: ;
      endcase
      m_stat = (m_stat & ~clr) | rise;
      s_new = LAT == 1 ? 64'(io_in) : last_pad;
      last_pad = 64'(io_in);
      samp.push_back(s_new);
      if (HREADY) begin
        pv = HSEL & HTRANS[1];
        if (pv) begin
          pa = HADDR[5:0];
          pw = HWRITE;
          pm32 = HSIZE == 3'd0 ? 32'hFF << (8 * HADDR[1:0]) :
                 HSIZE == 3'd1 ? 32'hFFFF << (16 * HADDR[1]) : 32'hFFFF_FFFF;
        end
      end
    end
    #1;
    check_all();
  endtask

  task automatic drive(input logic sel, input logic [1:0] tr, input logic w, input logic [5:0] a,
                       input logic [2:0] sz, input logic [31:0] d);
    HSEL = sel; HTRANS = tr; HWRITE = w; HADDR = {26'($urandom), a}; HSIZE = sz; HWDATA = d;
    tick();
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 1'b0, 6'h0, 3'd0, $urandom);
  endtask

  task automatic wr(input logic [5:0] a, input logic [2:0] sz, input logic [31:0] d);
    drive(1'b1, 2'b10, 1'b1, a, sz, $urandom);
    drive(1'b0, 2'b00, 1'b0, 6'h0, 3'd0, d);
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] q);
    drive(1'b1, 2'b10, 1'b0, a, 3'd2, $urandom);
    q = HRDATA;
    idle();
  endtask

  initial begin
    pv = 1'b0; pw = 1'b0; pa = '0; pm32 = '0; last_pad = '0; m_irq = 1'b0;
    m_out = '0; m_oeb = PM; m_en = '0; m_stat = '0;
    samp.push_back('0); samp.push_back('0);
    idle(); idle();
    rst_n = 1'b1;
    idle();
    // T1 reset values
    rd(6'h00, v); chk("t1_out_lo", 64'(v), 64'h0);
    rd(6'h08, v); chk("t1_oeb_lo", 64'(v), 64'hFFFF_FFFF);
    rd(6'h0C, v); chk("t1_oeb_hi", 64'(v), 64'h3F);
    rd(6'h20, v); chk("t1_stat_lo", 64'(v), 64'h0);
    chk("t1_io_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    // T2 word then byte write
    wr(6'h00, 3'd2, 32'hA5A5_A5A5);
    wr(6'h01, 3'd0, 32'h3C3C_3C3C);
    chk("t2_io_out", 64'(io_out[31:0]), 64'hA5A5_3CA5);
    rd(6'h00, v); chk("t2_readback", 64'(v), 64'hA5A5_3CA5);
    // T3 high word truncation
    wr(6'h04, 3'd2, 32'h3FFF_FFFF);
    chk("t3_io_out_hi", 64'(io_out[P-1:32]), 64'h3F);
    rd(6'h04, v); chk("t3_readback", 64'(v), 64'h3F);
    // T4 rising edge interrupt latency and W1C
    wr(6'h18, 3'd2, 32'h1);
    io_in[0] = 1'b1;
    n = 0;
    while (irq !== 1'b1 && n < 20) begin idle(); n++; end
    chk("t4_irq_latency", 64'(n), 64'(LAT + 2));
    rd(6'h20, v); chk("t4_stat", 64'(v), 64'h1);
    wr(6'h20, 3'd2, 32'h1);
    chk("t4_irq_before_drop", 64'(irq), 64'd1);
    idle();
    chk("t4_irq_dropped", 64'(irq), 64'd0);
    // T5 edge coinciding with W1C
    io_in[0] = 1'b0; repeat (4) idle();
    io_in[0] = 1'b1; repeat (LAT + 3) idle();
    chk("t5_irq_pre", 64'(irq), 64'd1);
    io_in[0] = 1'b0; repeat (4) idle();
    io_in[0] = 1'b1; repeat (LAT - 1) idle();
    wr(6'h20, 3'd2, 32'h1);
    chk("t5_irq_after_w1c", 64'(irq), 64'd1);
    rd(6'h20, v); chk("t5_stat", 64'(v), 64'h1);
    chk("t5_irq_hold", 64'(irq), 64'd1);
    // T6 back-to-back write/read, unmapped read, IDLE write
    drive(1'b1, 2'b10, 1'b1, 6'h08, 3'd2, $urandom);
    drive(1'b1, 2'b11, 1'b0, 6'h08, 3'd2, 32'h1234_5678);
    v = HRDATA;
    chk("t6_raw", 64'(v), 64'h1234_5678);
    idle();
    chk("t6_io_oeb", 64'(io_oeb[31:0]), 64'h1234_5678);
    rd(6'h30, v); chk("t6_unmapped", 64'(v), 64'h0);
    drive(1'b1, 2'b00, 1'b1, 6'h00, 3'd2, $urandom);
    drive(1'b0, 2'b00, 1'b0, 6'h00, 3'd0, 32'hDEAD_BEEF);
    chk("t6_idle_write", 64'(io_out[31:0]), 64'hA5A5_3CA5);
    // reset during a data phase abandons the write
    drive(1'b1, 2'b10, 1'b1, 6'h18, 3'd2, $urandom);
    rst_n = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 6'h00, 3'd0, 32'hFFFF_FFFF);
    rst_n = 1'b1;
    idle();
    rd(6'h18, v); chk("rst_abandon", 64'(v), 64'h0);
    chk("rst_io_oeb", 64'(io_oeb), PM);
    chk("rst_io_out", 64'(io_out), 64'h0);
    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      int sz;
      logic [5:0] a;
      if ($urandom_range(0, 2) == 0) io_in[$urandom_range(0, P-1)] ^= 1'b1;
      rst_n = $urandom_range(0, 199) != 0;
      sz = $urandom_range(0, 2);
      a = {4'($urandom_range(0, 15)), 2'b00};
      a[1:0] = sz == 0 ? 2'($urandom_range(0, 3)) : sz == 1 ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
      drive($urandom_range(0, 3) != 0, 2'($urandom), 1'($urandom), a, 3'(sz), $urandom);
    end
    rst_n = 1'b1;
    idle(); idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
